// File: rtl/alu_sequencer.sv
// Control sequencer for alu_block: takes one instruction byte per start pulse and steps
// through operand load, execute, flag capture and optional writeback, one state per cycle.
module alu_sequencer #(
  parameter logic [3:0] OUT_NONE = 4'd15,
  parameter logic [3:0] LD_NONE  = 4'd15,
  parameter logic [3:0] OUT_A    = 4'd0,
  parameter logic [3:0] OUT_RES  = 4'd2,
  parameter logic [3:0] LD_A     = 4'd0,
  parameter logic [3:0] LD_B     = 4'd1,
  parameter logic [2:0] ARG_IDLE = 3'd6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] instr,
  input  logic [3:0] flags_in,
  output logic       busy,
  output logic       done,
  output logic       src_rd,
  output logic       res_wr,
  output logic [3:0] outctl,
  output logic [3:0] loadctl,
  output logic [1:0] arg_l,
  output logic [2:0] arg_r,
  output logic       calcfn,
  output logic       alt,
  output logic       cin,
  output logic [3:0] flags
);

  localparam int unsigned OP_W    = 3;
  localparam int unsigned ARGL_W  = 2;
  localparam int unsigned ARGR_W  = 3;
  localparam int unsigned CTL_W   = 4;
  localparam int unsigned FLAG_W  = 4;
  localparam int unsigned CARRY   = 1;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADC = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SBC = OP_W'(3);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(4);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(6);
  localparam logic [OP_W-1:0] OP_CMP = OP_W'(7);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDB  = 3'd1,
    S_EXEC = 3'd2,
    S_FLAG = 3'd3,
    S_WB   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic                wb_q, wb_d;
  logic [ARGL_W-1:0]   argl_q, argl_d;

  logic                busy_d, done_d, src_rd_d, res_wr_d, calcfn_d, alt_d, cin_d;
  logic [CTL_W-1:0]    outctl_d, loadctl_d;
  logic [ARGL_W-1:0]   arg_l_d;
  logic [ARGR_W-1:0]   arg_r_d;
  logic [FLAG_W-1:0]   flags_d;

  // instr[2] carries no meaning for this sequencer
  logic unused_instr_bit;
  assign unused_instr_bit = instr[2];

  // Next state, then the registered controls decoded from the state being entered
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wb_d      = wb_q;
    argl_d    = argl_q;
    flags_d   = flags;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    src_rd_d  = 1'b0;
    res_wr_d  = 1'b0;
    outctl_d  = OUT_NONE;
    loadctl_d = LD_NONE;
    arg_l_d   = '0;
    arg_r_d   = ARG_IDLE;
    calcfn_d  = 1'b0;
    alt_d     = 1'b0;
    cin_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = instr[7:5];
          wb_d    = instr[3];
          argl_d  = instr[1:0];
          state_d = instr[4] ? S_EXEC : S_LDB;
        end
      end
      S_LDB:  state_d = S_EXEC;
      S_EXEC: state_d = S_FLAG;
      S_FLAG: begin
        flags_d = flags_in;
        state_d = wb_q ? S_WB : S_DONE;
      end
      S_WB:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_LDB: begin
        busy_d    = 1'b1;
        src_rd_d  = 1'b1;
        loadctl_d = LD_B;
        arg_l_d   = argl_d;
      end
      S_EXEC: begin
        busy_d    = 1'b1;
        outctl_d  = OUT_RES;
        calcfn_d  = 1'b1;
        arg_l_d   = argl_d;
        loadctl_d = (op_d == OP_CMP) ? LD_NONE : LD_A;
        // carry-in for ADC/SBC comes from the previous instruction's captured flags
        case (op_d)
          OP_ADD: arg_r_d = ARGR_W'(1);
          OP_SUB: begin arg_r_d = ARGR_W'(2); alt_d = 1'b1; cin_d = 1'b1; end
          OP_ADC: begin arg_r_d = ARGR_W'(1); cin_d = flags[CARRY]; end
          OP_SBC: begin arg_r_d = ARGR_W'(2); alt_d = 1'b1; cin_d = flags[CARRY]; end
          OP_AND: arg_r_d = ARGR_W'(3);
          OP_OR:  arg_r_d = ARGR_W'(4);
          OP_XOR: arg_r_d = ARGR_W'(5);
          OP_CMP: begin arg_r_d = ARGR_W'(2); alt_d = 1'b1; cin_d = 1'b1; end
          default: arg_r_d = ARG_IDLE;
        endcase
      end
      S_FLAG: begin
        busy_d  = 1'b1;
        arg_l_d = argl_d;
      end
      S_WB: begin
        busy_d   = 1'b1;
        res_wr_d = 1'b1;
        outctl_d = OUT_A;
        arg_l_d  = argl_d;
      end
      S_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, latched instruction fields and registered control outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wb_q    <= 1'b0;
      argl_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      src_rd  <= 1'b0;
      res_wr  <= 1'b0;
      outctl  <= OUT_NONE;
      loadctl <= LD_NONE;
      arg_l   <= '0;
      arg_r   <= ARG_IDLE;
      calcfn  <= 1'b0;
      alt     <= 1'b0;
      cin     <= 1'b0;
      flags   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wb_q    <= wb_d;
      argl_q  <= argl_d;
      busy    <= busy_d;
      done    <= done_d;
      src_rd  <= src_rd_d;
      res_wr  <= res_wr_d;
      outctl  <= outctl_d;
      loadctl <= loadctl_d;
      arg_l   <= arg_l_d;
      arg_r   <= arg_r_d;
      calcfn  <= calcfn_d;
      alt     <= alt_d;
      cin     <= cin_d;
      flags   <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural alu_block and bus model.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] instr;
  logic [3:0] flags_in;
  logic       busy, done, src_rd, res_wr, calcfn, alt, cin;
  logic [3:0] outctl, loadctl, flags;
  logic [1:0] arg_l;
  logic [2:0] arg_r;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] IDLE_VEC = {8'h00, 7'h00, 2'b00, 3'd6, 4'hF, 4'hF, 4'h0};

  alu_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .flags_in(flags_in),
    .busy(busy), .done(done), .src_rd(src_rd), .res_wr(res_wr),
    .outctl(outctl), .loadctl(loadctl), .arg_l(arg_l), .arg_r(arg_r),
    .calcfn(calcfn), .alt(alt), .cin(cin), .flags(flags)
  );

  always #5 clk = ~clk;

  // Behavioural alu_block: A/B registers, result mux, flag latch
  logic [7:0] ma, mb, operand, bus, beff, res, pre_val;
  logic [8:0] sum;
  logic [3:0] mfl, fout;
  logic       pre_en, c_bit, v_bit;

  always_comb begin
    beff  = alt ? ~mb : mb;
    sum   = {1'b0, ma} + {1'b0, beff} + 9'(cin);
    c_bit = 1'b0;
    v_bit = 1'b0;
    case (arg_r)
      3'd1, 3'd2: begin
        res   = sum[7:0];
        c_bit = sum[8];
        v_bit = (ma[7] == beff[7]) && (sum[7] != ma[7]);
      end
      3'd3:    res = ma & mb;
      3'd4:    res = ma | mb;
      3'd5:    res = ma ^ mb;
      default: res = ma;
    endcase
    fout = {res[7], res == 8'h00, c_bit, v_bit};
    if (src_rd)              bus = operand;
    else if (outctl == 4'd0) bus = ma;
    else if (outctl == 4'd2) bus = res;
    else                     bus = 8'h00;
  end

  always @(posedge clk) begin
    if (pre_en)              ma <= pre_val;
    else if (loadctl == 4'd0) ma <= bus;
    if (loadctl == 4'd1)     mb <= bus;
    if (calcfn)              mfl <= fout;
  end
  assign flags_in = mfl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctl_vec();
    return {8'h00, busy, done, src_rd, res_wr, calcfn, alt, cin, arg_l, arg_r, outctl, loadctl, flags};
  endfunction

  task automatic preload(input logic [7:0] v);
    @(negedge clk); pre_en = 1'b1; pre_val = v;
    @(negedge clk); pre_en = 1'b0;
  endtask

  // Per-run observations, cycle 1 is the cycle in which start is driven
  bit         saw_src, saw_wb;
  logic       ex_cin;
  logic [3:0] ex_ld;
  logic [2:0] ex_argr;
  logic [1:0] ex_argl;
  logic [7:0] wb_bus;

  task automatic run(input logic [7:0] ins, input logic [7:0] opnd, input bit repulse,
                     output int done_cyc);
    @(negedge clk);
    instr = ins; operand = opnd; start = 1'b1;
    done_cyc = 0; saw_src = 0; saw_wb = 0;
    ex_cin = 1'bx; ex_ld = 4'hx; ex_argr = 3'hx; ex_argl = 2'hx; wb_bus = 8'hxx;
    for (int c = 2; c <= 12 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (src_rd) saw_src = 1;
      if (calcfn) begin ex_cin = cin; ex_ld = loadctl; ex_argr = arg_r; ex_argl = arg_l; end
      if (res_wr) begin wb_bus = bus; saw_wb = 1; end
      if (done) done_cyc = c;
      start = repulse && (c == 2 || c == 3);
    end
    start = 1'b0;
  endtask

  int  dc;
  bit  stray;

  initial begin
    rst = 1'b0; start = 1'b0; instr = 8'h00; operand = 8'h00; pre_en = 1'b0; pre_val = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_vec", ctl_vec(), IDLE_VEC);
    rst = 1'b1;

    // 1: 24 + 18 with writeback, arg_l=1
    preload(8'd24);
    run(8'h09, 8'd18, 0, dc);
    chk("t1_latency", 32'(dc), 32'd6);
    chk("t1_wb_bus", 32'(wb_bus), 32'd42);
    chk("t1_flags", 32'(flags), 32'h0);
    chk("t1_src_rd", 32'(saw_src), 32'd1);
    chk("t1_arg_r", 32'(ex_argr), 32'd1);
    chk("t1_arg_l", 32'(ex_argl), 32'd1);

    // 2: 42 + 214 wraps to zero with carry
    run(8'h00, 8'd214, 0, dc);
    chk("t2_latency", 32'(dc), 32'd5);
    chk("t2_flags", 32'(flags), 32'h6);
    chk("t2_a", 32'(ma), 32'd0);

    // 3: ADC picks up C from test 2
    run(8'h40, 8'd5, 0, dc);
    chk("t3_cin", 32'(ex_cin), 32'd1);
    chk("t3_a", 32'(ma), 32'd6);
    chk("t3_flags", 32'(flags), 32'h0);

    // 4: CMP leaves A untouched
    preload(8'd42);
    run(8'hE0, 8'd42, 0, dc);
    chk("t4_a", 32'(ma), 32'd42);
    chk("t4_loadctl", 32'(ex_ld), 32'd15);
    chk("t4_flags", 32'(flags), 32'h6);
    chk("t4_arg_r", 32'(ex_argr), 32'd2);

    // 5: reset during EXEC aborts the sequence
    @(negedge clk); instr = 8'h80; operand = 8'h11; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("t5_ldb", 32'(src_rd), 32'd1);
    @(negedge clk);
    chk("t5_exec", 32'(calcfn), 32'd1);
    #1 rst = 1'b0;
    #1 chk("t5_reset_vec", ctl_vec(), IDLE_VEC);
    stray = 0;
    @(negedge clk); rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) stray = 1;
    end
    chk("t5_no_done", 32'(stray), 32'd0);
    preload(8'hF0);
    run(8'h80, 8'h3C, 0, dc);
    chk("t5_and_latency", 32'(dc), 32'd5);
    chk("t5_and_a", 32'(ma), 32'h30);
    chk("t5_and_flags", 32'(flags), 32'h0);

    // 6: OR with reuse_b, start re-pulsed while busy
    run(8'hB0, 8'h99, 1, dc);
    chk("t6_latency", 32'(dc), 32'd4);
    chk("t6_src_rd", 32'(saw_src), 32'd0);
    chk("t6_a", 32'(ma), 32'h3C);
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy || done) stray = 1;
    end
    chk("t6_not_queued", 32'(stray), 32'd0);

    // 7: SUB with writeback, arg_l=2
    run(8'h2A, 8'h0C, 0, dc);
    chk("t7_latency", 32'(dc), 32'd6);
    chk("t7_wb_bus", 32'(wb_bus), 32'h30);
    chk("t7_flags", 32'(flags), 32'h2);
    chk("t7_arg_l", 32'(ex_argl), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
